// File: rtl/apb_slave_mem.sv
// APB completer backed by a word-addressed register memory, with configurable wait states and
// PSLVERR on unaligned or out-of-range addresses. Define APB_SLV_PSTRB_EN to add byte strobes.
module apb_slave_mem #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned MEM_DEPTH   = 16,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
`ifdef APB_SLV_PSTRB_EN
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
`endif
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
   localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [63:0] MEM_BYTES = 64'(MEM_DEPTH) * 64'(BYTES);
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BYTES - 1);

   typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

   state_e                  state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic                    write_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic                    err_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
   logic [BYTES-1:0]        wr_strb;

   logic                    capture;
   logic                    enter_ready;
   logic                    commit;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic                    sel_write;
   logic                    cur_err;
   logic [IDX_W-1:0]        cur_idx;

`ifdef APB_SLV_PSTRB_EN
   logic [BYTES-1:0]        strb_q;
   assign wr_strb = strb_q;
`else
   assign wr_strb = '1;
`endif

   // With zero wait states READY is entered on the setup edge, so decode the live bus in IDLE.
   assign sel_addr  = (state_q == StIdle) ? PADDR  : addr_q;
   assign sel_write = (state_q == StIdle) ? PWRITE : write_q;
   assign cur_err   = (|(sel_addr & OFF_MASK)) || (64'(sel_addr) >= MEM_BYTES);
   assign cur_idx   = IDX_W'(sel_addr >> OFF_W);

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      capture     = 1'b0;
      enter_ready = 1'b0;
      commit      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (PSEL && !PENABLE) begin
               capture = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_d     = StReady;
                  enter_ready = 1'b1;
               end else begin
                  state_d = StWait;
                  cnt_d   = 8'(WAIT_STATES);
               end
            end
         end
         StWait: begin
            if (!PSEL) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (PENABLE) begin
               if (cnt_q <= 8'd1) begin
                  state_d     = StReady;
                  enter_ready = 1'b1;
                  cnt_d       = '0;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         StReady: begin
            if (!PSEL) begin
               state_d = StIdle;
            end else if (PENABLE) begin
               commit  = write_q && !err_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      PREADY  = (state_q == StReady);
      PSLVERR = PREADY && err_q;
      PRDATA  = PREADY ? rdata_q : '0;
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
`ifdef APB_SLV_PSTRB_EN
         strb_q  <= '0;
`endif
      end else begin
         cnt_q <= cnt_d;
         if (capture) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            err_q   <= cur_err;
`ifdef APB_SLV_PSTRB_EN
            strb_q  <= PSTRB;
`endif
         end
         if (enter_ready) begin
            rdata_q <= (!sel_write && !cur_err) ? mem_q[cur_idx] : '0;
         end else if (state_d != StReady) begin
            rdata_q <= '0;
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         for (int i = 0; i < int'(MEM_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (commit) begin
         for (int b = 0; b < int'(BYTES); b++) begin
            if (wr_strb[b]) begin
               mem_q[cur_idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: DUT 0 has one wait state, DUT 1 has none; a scoreboard of expected
// responses is filled as transfers are issued and drained as PREADY is seen.
module tb_apb_slave_mem;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        prst    [2];
   logic        psel    [2];
   logic        penable [2];
   logic        pwrite  [2];
   logic [31:0] paddr   [2];
   logic [31:0] pwdata  [2];
   logic [31:0] prdata  [2];
   logic        pready  [2];
   logic        pslverr [2];
`ifdef APB_SLV_PSTRB_EN
   logic [3:0]  pstrb   [2];
`endif

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      string       name;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] mdl [2][16];
   int          checks   = 0;
   int          failures = 0;

   apb_slave_mem #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_DEPTH  (16),
      .WAIT_STATES(1)
   ) u_dut0 (
      .PCLK   (clk),
      .PRESETn(prst[0]),
      .PSEL   (psel[0]),
      .PENABLE(penable[0]),
      .PWRITE (pwrite[0]),
      .PADDR  (paddr[0]),
      .PWDATA (pwdata[0]),
`ifdef APB_SLV_PSTRB_EN
      .PSTRB  (pstrb[0]),
`endif
      .PRDATA (prdata[0]),
      .PREADY (pready[0]),
      .PSLVERR(pslverr[0])
   );

   apb_slave_mem #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_DEPTH  (16),
      .WAIT_STATES(0)
   ) u_dut1 (
      .PCLK   (clk),
      .PRESETn(prst[1]),
      .PSEL   (psel[1]),
      .PENABLE(penable[1]),
      .PWRITE (pwrite[1]),
      .PADDR  (paddr[1]),
      .PWDATA (pwdata[1]),
`ifdef APB_SLV_PSTRB_EN
      .PSTRB  (pstrb[1]),
`endif
      .PRDATA (prdata[1]),
      .PREADY (pready[1]),
      .PSLVERR(pslverr[1])
   );

   task automatic clear_model(input int d);
      for (int i = 0; i < 16; i++) mdl[d][i] = 32'h0;
   endtask

   // Issue one full transfer on DUT d; the expected response is queued before driving.
   task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb, input string name);
      exp_t        e;
      exp_t        got;
      logic [3:0]  s;
      logic [31:0] w;
      int          cyc;
      bit          done;
`ifdef APB_SLV_PSTRB_EN
      s = strb;
`else
      s = 4'hF;
`endif
      e.err   = (addr[1:0] != 2'b00) || (addr >= 32'd64);
      e.rdata = (!wr && !e.err) ? mdl[d][addr[5:2]] : 32'h0;
      e.lat   = (d == 0) ? 2 : 1;
      e.name  = name;
      sb.push_back(e);
      if (wr && !e.err) begin
         w = mdl[d][addr[5:2]];
         for (int b = 0; b < 4; b++) if (s[b]) w[b*8 +: 8] = wdata[b*8 +: 8];
         mdl[d][addr[5:2]] = w;
      end
      psel[d]    = 1'b1;
      penable[d] = 1'b0;
      pwrite[d]  = wr;
      paddr[d]   = addr;
      pwdata[d]  = wdata;
`ifdef APB_SLV_PSTRB_EN
      pstrb[d]   = strb;
`endif
      @(posedge clk); #1;
      penable[d] = 1'b1;
      cyc  = 1;
      done = 1'b0;
      while (!done && cyc <= 20) begin
         @(negedge clk);
         if (pready[d] === 1'b1) begin
            got = sb.pop_front();
            checks += 3;
            if (prdata[d] !== got.rdata) begin
               failures++;
               $display("FAIL %s prdata: got %h expected %h", got.name, prdata[d], got.rdata);
            end
            if (pslverr[d] !== got.err) begin
               failures++;
               $display("FAIL %s pslverr: got %b expected %b", got.name, pslverr[d], got.err);
            end
            if (cyc !== got.lat) begin
               failures++;
               $display("FAIL %s latency: got %0d expected %0d", got.name, cyc, got.lat);
            end
            done = 1'b1;
         end
         @(posedge clk); #1;
         if (!done) cyc++;
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL %s timeout: PREADY not seen in 20 cycles", name);
         got = sb.pop_front();
      end
      psel[d]    = 1'b0;
      penable[d] = 1'b0;
   endtask

   // PREADY/PSLVERR/PRDATA must all stay low for n cycles.
   task automatic expect_quiet(input int d, input int n, input string name);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         checks++;
         if ({pready[d], pslverr[d], prdata[d]} !== 34'h0) begin
            failures++;
            $display("FAIL %s quiet: got pready=%b pslverr=%b prdata=%h expected all 0",
                     name, pready[d], pslverr[d], prdata[d]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      prst[0] = 1'b0;
      prst[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) clear_model(d);
      for (int d = 0; d < 2; d++) begin
         checks += 3;
         if (pready[d] !== 1'b0) begin
            failures++;
            $display("FAIL reset_pready dut%0d: got %b expected 0", d, pready[d]);
         end
         if (pslverr[d] !== 1'b0) begin
            failures++;
            $display("FAIL reset_pslverr dut%0d: got %b expected 0", d, pslverr[d]);
         end
         if (prdata[d] !== 32'h0) begin
            failures++;
            $display("FAIL reset_prdata dut%0d: got %h expected 0", d, prdata[d]);
         end
      end
      prst[0] = 1'b1;
      prst[1] = 1'b1;
      xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, "reset_read0");
   endtask

   task automatic test_write_read();
      xfer(0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, "wr_0x8");
      xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, "rd_0x8");
   endtask

   task automatic test_out_of_range();
      xfer(0, 1'b1, 32'h0, 32'h0BADC0DE, 4'hF, "wr_0x0");
      xfer(0, 1'b1, 32'h40, 32'h12345678, 4'hF, "wr_oor_0x40");
      xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, "rd_0x0_after_oor");
      xfer(0, 1'b0, 32'h40, 32'h0, 4'hF, "rd_oor_0x40");
      xfer(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, "rd_oor_top");
   endtask

   task automatic test_unaligned();
      xfer(0, 1'b1, 32'h4, 32'h44443333, 4'hF, "wr_0x4");
      xfer(0, 1'b0, 32'h6, 32'h0, 4'hF, "rd_unaligned_0x6");
      xfer(0, 1'b1, 32'h5, 32'h99999999, 4'hF, "wr_unaligned_0x5");
      xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, "rd_0x4_after_unaligned");
   endtask

   task automatic test_back_to_back();
      xfer(1, 1'b1, 32'hC, 32'hA5A5A5A5, 4'hF, "b2b_wr_0xC");
      xfer(1, 1'b0, 32'hC, 32'h0, 4'hF, "b2b_rd_0xC");
      xfer(1, 1'b1, 32'h3C, 32'h5A5A0001, 4'hF, "b2b_wr_0x3C");
      xfer(1, 1'b0, 32'h3C, 32'h0, 4'hF, "b2b_rd_0x3C");
      xfer(1, 1'b0, 32'hC, 32'h0, 4'hF, "b2b_rd_0xC_again");
   endtask

   task automatic test_random();
      for (int i = 0; i < 24; i++) begin
         int          d;
         bit          wr;
         logic [31:0] a;
         d  = i % 2;
         wr = 1'($urandom_range(0, 1));
         a  = 32'($urandom_range(0, 17)) * 32'd4 + ((i % 7 == 0) ? 32'd2 : 32'd0);
         xfer(d, wr, a, $urandom, 4'($urandom_range(0, 15)), $sformatf("rand%0d", i));
      end
   endtask

   task automatic test_abort();
      // PSEL dropped in WAIT.
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
      paddr[0] = 32'h4; pwdata[0] = 32'h11111111;
`ifdef APB_SLV_PSTRB_EN
      pstrb[0] = 4'hF;
`endif
      @(posedge clk); #1;
      psel[0] = 1'b0;
      expect_quiet(0, 3, "abort_psel");
      xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, "rd_0x4_after_abort");
      // Reset pulsed in WAIT.
      psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
      paddr[0] = 32'h4; pwdata[0] = 32'h11111111;
      @(posedge clk); #1;
      penable[0] = 1'b1;
      prst[0] = 1'b0;
      @(posedge clk); #1;
      prst[0] = 1'b1;
      psel[0] = 1'b0; penable[0] = 1'b0;
      clear_model(0);
      expect_quiet(0, 2, "abort_reset");
      xfer(0, 1'b0, 32'h4, 32'h0, 4'hF, "rd_0x4_after_reset");
      xfer(0, 1'b0, 32'h8, 32'h0, 4'hF, "rd_0x8_after_reset");
      // Access phase without setup in IDLE is ignored.
      psel[1] = 1'b1; penable[1] = 1'b1; pwrite[1] = 1'b1; paddr[1] = 32'h0;
      expect_quiet(1, 3, "idle_penable");
      psel[1] = 1'b0; penable[1] = 1'b0;
   endtask

`ifdef APB_SLV_PSTRB_EN
   task automatic test_pstrb();
      xfer(0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'b0101, "strb_wr_0101");
      xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, "strb_rd_0x0");
      xfer(0, 1'b1, 32'h0, 32'h12345678, 4'b0000, "strb_wr_none");
      xfer(0, 1'b0, 32'h0, 32'h0, 4'b0000, "strb_rd_after_none");
      xfer(0, 1'b1, 32'h0, 32'hAABBCCDD, 4'b1000, "strb_wr_1000");
      xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, "strb_rd_after_1000");
   endtask
`endif

   initial begin
      for (int d = 0; d < 2; d++) begin
         prst[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
         paddr[d] = 32'h0; pwdata[d] = 32'h0;
`ifdef APB_SLV_PSTRB_EN
         pstrb[d] = 4'hF;
`endif
      end
      @(posedge clk); #1;
      test_reset();
      test_write_read();
      test_out_of_range();
      test_unaligned();
      test_back_to_back();
      test_random();
      test_abort();
`ifdef APB_SLV_PSTRB_EN
      test_pstrb();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
APB completer (slave) that terminates the master-side APB bus driven by the testbench driver or an upstream bridge. It implements a word-addressed register memory with parameterised wait states and PSLVERR on illegal addresses. It is used as the DUT and reference responder for APB master verification, and as a simple peripheral model in SoC benches.

Parameters:
ADDR_WIDTH, 32, PADDR width
DATA_WIDTH, 32, PWDATA/PRDATA width (multiple of 8)
MEM_DEPTH, 16, number of DATA_WIDTH words; legal byte range 0 .. MEM_DEPTH*(DATA_WIDTH/8)-1
WAIT_STATES, 1, PREADY-low cycles inserted in the ACCESS phase (0..255)

Ports:
PCLK  input  1  clock; all logic on posedge
PRESETn  input  1  synchronous active-low reset
PSEL  input  1  slave select
PENABLE  input  1  access phase strobe
PWRITE  input  1  1=write, 0=read
PADDR  input  ADDR_WIDTH  byte address
PWDATA  input  DATA_WIDTH  write data
PRDATA  output  DATA_WIDTH  read data, valid only while PREADY=1
PREADY  output  1  transfer completion, registered
PSLVERR  output  1  error response, valid only while PREADY=1

Behaviour:
- One clock PCLK. Reset PRESETn is synchronous and active-low.
- Reset (PRESETn=0 at posedge):
  - state goes to IDLE.
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - The wait counter is cleared.
  - All memory words are cleared to 0.
- Reset has priority over every other event. A reset mid-transfer aborts the transfer and no write is committed.
- FSM states are IDLE, WAIT and READY.
- IDLE:
  - A posedge with PSEL=1 and PENABLE=0 (setup phase) captures PADDR, PWRITE and PWDATA.
  - The error flag is computed: err = (PADDR[1:0]!=0 for 32-bit data; generally the low log2(DATA_WIDTH/8) bits nonzero) OR (PADDR >= MEM_DEPTH*DATA_WIDTH/8).
  - If WAIT_STATES==0, the next state is READY.
  - Otherwise the next state is WAIT, with cnt=WAIT_STATES.
- WAIT:
  - While PSEL=1 and PENABLE=1, cnt decrements each posedge.
  - When cnt==1 at a posedge, the next state is READY.
- Entry into READY (registered, same edge as the transition):
  - PREADY goes to 1 and PSLVERR goes to err.
  - For a read with err=0, PRDATA = mem[index].
  - For a read with err=1, or for any write, PRDATA = 0.
- READY:
  - At the posedge with PSEL=1, PENABLE=1 and PREADY=1 the transfer completes.
  - A write with err=0 commits the captured PWDATA to mem[index].
  - A write with err=1 is discarded.
  - Outputs return to 0 and the next state is IDLE.
- Resulting latency: PREADY is high in ACCESS cycle WAIT_STATES+1. A transfer therefore takes WAIT_STATES+2 cycles including setup.
- Back-to-back transfers: a new setup phase in the cycle directly after completion is accepted from IDLE. There is no dead cycle.
- index = captured PADDR >> log2(DATA_WIDTH/8), truncated to clog2(MEM_DEPTH) bits.
- A read following a write to the same address returns the new data.
- Protocol violation: if PSEL=0 at any posedge in WAIT or READY, the FSM aborts to IDLE with all outputs 0 and no write.
- In IDLE, PENABLE=1 without a preceding setup phase is ignored.
- PREADY, PSLVERR and PRDATA are 0 whenever the state is not READY.
- No X is allowed on outputs after reset.

Optional Feature:
APB_SLV_PSTRB_EN
- Defined:
  - Adds input port PSTRB, width DATA_WIDTH/8, captured in the setup phase.
  - On write commit, only the bytes with PSTRB[i]=1 are updated. Unselected bytes retain their old value.
  - PSTRB=0 with err=0 completes normally and changes no memory.
  - Reads ignore PSTRB.
- Undefined:
  - The PSTRB port is absent and every legal write updates the full word.

Test Plan:
- Reset then read: PRESETn=0 for 2 cycles, then read addr 0x0 with WAIT_STATES=1 -> PREADY high in the 2nd ACCESS cycle, PRDATA=0x00000000, PSLVERR=0.
- Write then read back: write 0xDEADBEEF to 0x8, then read 0x8 -> PRDATA=0xDEADBEEF, PSLVERR=0. Each transfer takes 3 cycles with WAIT_STATES=1.
- Out of range: write 0x12345678 to 0x40 (MEM_DEPTH=16) -> PSLVERR=1 with PREADY. A subsequent read of 0x0 is unchanged, and a read of 0x40 gives PSLVERR=1 and PRDATA=0.
- Unaligned: read 0x6 -> PSLVERR=1, PRDATA=0. Write to 0x5 -> no memory change at 0x4.
- Back-to-back with WAIT_STATES=0: write 0xA5A5A5A5 to 0xC, then setup for a read of 0xC in the very next cycle -> PREADY high in the first ACCESS cycle of both transfers, read returns 0xA5A5A5A5.
- Abort/reset: mid-WAIT of a write of 0x11111111 to 0x4, drop PSEL (or pulse PRESETn=0) -> PREADY never rises, the FSM returns to IDLE, and a read of 0x4 returns its prior value (0 after reset). With APB_SLV_PSTRB_EN, a write of 0xFFFFFFFF with PSTRB=4'b0101 over 0x0 -> read returns 0x00FF00FF.
